mem_access_aligner: RTL and testbench
=====================================

Name: mem_access_aligner

Overview:
- Sits directly upstream of the byte-masked data memory (1-cycle registered read, masked write) in the CPU load/store path.
- Accepts byte-addressed load/store requests of size byte/half/word/dword.
- Turns each request into word-addressed memory accesses with write masks and shifted data. Misaligned accesses are split into two beats.
- For loads, extracts the requested bytes from memory read data and zero- or sign-extends them as the response.

Parameters:
- MEM_WIDTH_BYTES, 4: memory word width in bytes; power of two, 2..8.
- MEM_DEPTH, 1024: memory depth in words; power of two.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_in  in  1  request present
- req_ready_out  out  1  request accepted when valid&&ready
- req_write_in  in  1  1=store, 0=load
- req_addr_in  in  AW=$clog2(MEM_DEPTH)+$clog2(MEM_WIDTH_BYTES)  byte address
- req_size_in  in  2  0=B, 1=H, 2=W, 3=D
- req_signed_in  in  1  sign-extend load result
- req_data_in  in  MEM_WIDTH_BYTES*8  store data, right-justified
- resp_valid_out  out  1  load result valid; no backpressure
- resp_data_out  out  MEM_WIDTH_BYTES*8  extended load result
- mem_write_addr_out  out  $clog2(MEM_DEPTH)  memory write word address
- mem_write_out  out  1  memory write strobe
- mem_write_data_out  out  MEM_WIDTH_BYTES*8  memory write data
- mem_write_mask_out  out  MEM_WIDTH_BYTES  memory byte-enable mask
- mem_read_addr_out  out  $clog2(MEM_DEPTH)  memory read word address
- mem_read_out  out  1  memory read strobe
- mem_read_data_in  in  MEM_WIDTH_BYTES*8  memory read data, valid 1 cycle after read address
- debugen_in  in  1  enables $write trace of each accepted request and response

Behaviour:
- Definitions:
  - N = 1<<size; off = addr[low bits]; word = addr >> log2(MEM_WIDTH_BYTES).
  - Misaligned when off+N > MEM_WIDTH_BYTES.
  - N > MEM_WIDTH_BYTES is illegal: prints a warning when debugen_in is set; the result is undefined.
- States: IDLE, LD2 (second load beat), ST2 (second store beat).
- Reset:
  - State goes to IDLE; all pipeline valids clear.
  - During reset: req_ready_out=0, resp_valid_out=0, mem_write_out=0, mem_read_out=0.
  - Reset mid-split abandons the second beat; no beat-1 write, no response.
- req_ready_out is 1 in IDLE and 0 in LD2/ST2.
- Memory-side signals are combinational from the accepted request in the accept cycle T; memory registers them at the edge.
- Aligned store at T:
  - mem_write_out=1, addr=word.
  - mask = ((1<<N)-1)<<off.
  - data = req_data_in<<(8*off).
  - No response. Stays in IDLE.
- Misaligned store at T:
  - Beat 0 at T: word, mask and data as above, truncated to the word.
  - Captures the overflow mask/data; goes to ST2.
  - T+1: beat 1 writes word+1 with mask = full mask >> MEM_WIDTH_BYTES and data = full shifted data >> (8*MEM_WIDTH_BYTES).
  - Then returns to IDLE.
- Aligned load at T:
  - mem_read_out=1, read addr=word.
  - off/size/signed are registered.
  - T+1: resp_valid_out=1; resp_data_out = extend((mem_read_data_in >> 8*off) & N-byte mask).
  - Back-to-back aligned loads give throughput 1/cycle.
- Misaligned load at T:
  - T: read word; goes to LD2.
  - T+1: reads word+1; captures mem_read_data_in as low word.
  - T+2: resp_valid_out=1; data = extend(({read_data, low} >> 8*off) truncated to N bytes); state back to IDLE, so a new request may be accepted at T+2.
- Word address arithmetic is modulo MEM_DEPTH: word+1 of the last word wraps to 0.
- Extension: if signed, the MSB of byte N-1 is replicated; otherwise zero-filled. Size == MEM_WIDTH_BYTES needs no extension.
- Simultaneity:
  - The memory write and read of a store followed by a load to the same word in the next cycle: the load returns the new data.
  - A response from the previous request and acceptance of a new one may coincide.
- resp_valid_out is high only in response cycles, for exactly one cycle per load.

Decomposition:
- Shared package mem_access_pkg holds:
  - typedef enum for size (SIZE_B/H/W/D);
  - typedef enum for state (IDLE/LD2/ST2);
  - a function size_mask(size) returning the N-byte mask.
- One sub-module: mem_load_extract, purely combinational.
  - Inputs: the concatenated data, off, size, signed.
  - Output: the extended result.
  - Used in both the aligned and the misaligned response path.

Test Plan:
- MEM_WIDTH_BYTES=4. Word store 0x11223344 @0x10 -> mem write addr 4, mask 4'hF, data 0x11223344. Word load @0x10 at T -> resp_valid at T+1, data 0x11223344.
- Byte store 0xAB @0x13 -> mask 4'b1000, data 0xAB000000. Signed byte load @0x13 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half store 0xBEEF @0x17:
  - T: addr 5, mask 4'b1000, data 0xEF000000.
  - T+1: addr 6, mask 4'b0001, data 0x000000BE; ready=0.
  - Signed half load @0x17 -> resp at T+2, data 0xFFFFBEEF.
- Word load @ byte (MEM_DEPTH*4-2) -> reads word MEM_DEPTH-1 then word 0. Result assembled from the top two bytes of the last word and the low two bytes of word 0.
- Three aligned word loads on consecutive cycles -> three consecutive resp_valid cycles with matching data.
- Misaligned store accepted at T, reset asserted at T+1 -> no write at T+1; resp_valid_out=0; req_ready_out=1 after reset is released.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared types and helpers for the load/store memory aligner:
//                access-size and controller-state enumerations, plus the
//                byte-mask helper for an access of a given size.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Access size: the number of bytes is 1 << size.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    // Controller state: second beats of split loads and stores.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD2  = 2'd1,
        ST2  = 2'd2
    } state_e;

    // Right-justified byte mask covering the bytes of one access.
    function automatic logic [7:0] size_mask(input size_e size);
        logic [7:0] mask;
        case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_load_extract.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_extract
//  Description : Combinational load-result extraction. Shifts a two-word
//                window right by the byte offset, keeps the requested number
//                of bytes and zero- or sign-extends to the word width.
//  Ports       : i_data   - {high word, low word} read window
//                i_off    - byte offset of the access within the low word
//                i_size   - access size
//                i_signed - sign-extend when set
//                o_result - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extract
    import mem_access_pkg::*;
#(
    parameter int MEM_WIDTH_BYTES = 4,
    localparam int DW = 8 * MEM_WIDTH_BYTES,
    localparam int OW = $clog2(MEM_WIDTH_BYTES)
) (
    input  logic [2*DW-1:0] i_data,
    input  logic [OW-1:0]   i_off,
    input  size_e           i_size,
    input  logic            i_signed,
    output logic [DW-1:0]   o_result
);

    logic [DW-1:0] w_shift;
    logic [4:0]    w_nbytes;
    logic          w_sign;

    always_comb begin
        w_shift  = DW'(i_data >> {i_off, 3'b000});
        w_nbytes = 5'd1 << i_size;
        w_sign   = 1'b0;
        o_result = '0;
        // Sign bit is the MSB of the last byte that belongs to the access.
        for (int b = 0; b < MEM_WIDTH_BYTES; b++) begin
            if (5'(b) + 5'd1 == w_nbytes) begin
                w_sign = w_shift[8*b+7];
            end
        end
        // A full-width access keeps every byte, so no extension happens.
        for (int b = 0; b < MEM_WIDTH_BYTES; b++) begin
            if (5'(b) < w_nbytes) begin
                o_result[8*b +: 8] = w_shift[8*b +: 8];
            end else begin
                o_result[8*b +: 8] = {8{i_signed & w_sign}};
            end
        end
    end

endmodule : mem_load_extract
`default_nettype wire

// File: rtl/mem_access_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_aligner
//  Description : Converts byte-addressed load/store requests into word
//                accesses of a byte-masked memory with a 1-cycle registered
//                read. Accesses crossing a word boundary are split into two
//                beats; load results are extracted and extended.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                req_*                 - request handshake and payload
//                resp_valid_out/data   - load result (one cycle per load)
//                mem_write_*           - memory write port (masked)
//                mem_read_*            - memory read port, data 1 cycle later
//                debugen_in            - enables request/response trace
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_aligner
    import mem_access_pkg::*;
#(
    parameter int MEM_WIDTH_BYTES = 4,
    parameter int MEM_DEPTH       = 1024,
    localparam int DW  = 8 * MEM_WIDTH_BYTES,
    localparam int OW  = $clog2(MEM_WIDTH_BYTES),
    localparam int WAW = $clog2(MEM_DEPTH),
    localparam int AW  = WAW + OW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid_in,
    output logic                       req_ready_out,
    input  logic                       req_write_in,
    input  logic [AW-1:0]              req_addr_in,
    input  logic [1:0]                 req_size_in,
    input  logic                       req_signed_in,
    input  logic [DW-1:0]              req_data_in,
    output logic                       resp_valid_out,
    output logic [DW-1:0]              resp_data_out,
    output logic [WAW-1:0]             mem_write_addr_out,
    output logic                       mem_write_out,
    output logic [DW-1:0]              mem_write_data_out,
    output logic [MEM_WIDTH_BYTES-1:0] mem_write_mask_out,
    output logic [WAW-1:0]             mem_read_addr_out,
    output logic                       mem_read_out,
    input  logic [DW-1:0]              mem_read_data_in,
    input  logic                       debugen_in
);

    state_e                       r_state;
    state_e                       w_state_nxt;

    // Second store beat, captured at acceptance.
    logic [WAW-1:0]               r_st_addr;
    logic [MEM_WIDTH_BYTES-1:0]   r_st_mask;
    logic [DW-1:0]                r_st_data;

    // Load context carried to the response cycle.
    logic [WAW-1:0]               r_ld_addr;
    logic [OW-1:0]                r_off;
    size_e                        r_size;
    logic                         r_signed;
    logic [DW-1:0]                r_low;
    logic                         r_resp_pend;
    logic                         r_resp_mis;

    logic                         w_accept;
    logic [OW-1:0]                w_off;
    logic [WAW-1:0]               w_word;
    logic [4:0]                   w_nbytes;
    logic                         w_misaligned;
    logic [2*MEM_WIDTH_BYTES-1:0] w_full_mask;
    logic [2*DW-1:0]              w_full_data;
    logic [2*DW-1:0]              w_ext_data;

    assign w_off        = req_addr_in[OW-1:0];
    assign w_word       = req_addr_in[AW-1:OW];
    assign w_nbytes     = 5'd1 << req_size_in;
    assign w_misaligned = (5'(w_off) + w_nbytes) > 5'(MEM_WIDTH_BYTES);
    assign w_accept     = req_valid_in & req_ready_out;

    // Two-word-wide mask and data; the upper word is the second beat.
    assign w_full_mask = {{MEM_WIDTH_BYTES{1'b0}},
                          MEM_WIDTH_BYTES'(size_mask(size_e'(req_size_in)))} << w_off;
    assign w_full_data = {{DW{1'b0}}, req_data_in} << {w_off, 3'b000};

    always_comb begin
        w_state_nxt        = r_state;
        req_ready_out      = 1'b0;
        mem_write_out      = 1'b0;
        mem_write_addr_out = w_word;
        mem_write_mask_out = w_full_mask[MEM_WIDTH_BYTES-1:0];
        mem_write_data_out = w_full_data[DW-1:0];
        mem_read_out       = 1'b0;
        mem_read_addr_out  = w_word;
        // Outputs stay quiet throughout reset so an abandoned split never
        // issues its second beat.
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    req_ready_out = 1'b1;
                    if (req_valid_in) begin
                        if (req_write_in) begin
                            mem_write_out = 1'b1;
                            if (w_misaligned) w_state_nxt = ST2;
                        end else begin
                            mem_read_out = 1'b1;
                            if (w_misaligned) w_state_nxt = LD2;
                        end
                    end
                end
                LD2: begin
                    mem_read_out      = 1'b1;
                    mem_read_addr_out = r_ld_addr;
                    w_state_nxt       = IDLE;
                end
                ST2: begin
                    mem_write_out      = 1'b1;
                    mem_write_addr_out = r_st_addr;
                    mem_write_mask_out = r_st_mask;
                    mem_write_data_out = r_st_data;
                    w_state_nxt        = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_resp_pend <= 1'b0;
            r_resp_mis  <= 1'b0;
            r_st_addr   <= '0;
            r_st_mask   <= '0;
            r_st_data   <= '0;
            r_ld_addr   <= '0;
            r_off       <= '0;
            r_size      <= SIZE_B;
            r_signed    <= 1'b0;
            r_low       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_resp_pend <= 1'b0;
            r_resp_mis  <= 1'b0;
            if (w_accept && req_write_in && w_misaligned) begin
                r_st_addr <= w_word + WAW'(1);
                r_st_mask <= w_full_mask[2*MEM_WIDTH_BYTES-1:MEM_WIDTH_BYTES];
                r_st_data <= w_full_data[2*DW-1:DW];
            end
            if (w_accept && !req_write_in) begin
                r_off     <= w_off;
                r_size    <= size_e'(req_size_in);
                r_signed  <= req_signed_in;
                r_ld_addr <= w_word + WAW'(1);
                if (!w_misaligned) r_resp_pend <= 1'b1;
            end
            // First word of a split load arrives while the second is read.
            if (r_state == LD2) begin
                r_low       <= mem_read_data_in;
                r_resp_pend <= 1'b1;
                r_resp_mis  <= 1'b1;
            end
        end
    end

    assign resp_valid_out = r_resp_pend & ~reset;
    assign w_ext_data     = r_resp_mis ? {mem_read_data_in, r_low}
                                       : {{DW{1'b0}}, mem_read_data_in};

    mem_load_extract #(
        .MEM_WIDTH_BYTES (MEM_WIDTH_BYTES)
    ) u_extract (
        .i_data   (w_ext_data),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_result (resp_data_out)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && debugen_in) begin
            if (w_accept) begin
                $write("[%0t] mem_access_aligner: %s addr=%h size=%0d data=%h\n",
                       $time, req_write_in ? "ST" : "LD", req_addr_in,
                       req_size_in, req_data_in);
                if (w_nbytes > 5'(MEM_WIDTH_BYTES)) begin
                    $write("[%0t] mem_access_aligner: warning: access size exceeds memory width\n",
                           $time);
                end
            end
            if (resp_valid_out) begin
                $write("[%0t] mem_access_aligner: RESP data=%h\n", $time, resp_data_out);
            end
        end
    end
`endif

endmodule : mem_access_aligner
`default_nettype wire

// File: tb/tb_mem_access_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_aligner
//  Description : Self-checking bench for mem_access_aligner. A byte-array
//                reference memory tracks every request; a word memory model
//                serves the DUT's memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_aligner;

    localparam int W     = 4;
    localparam int DEPTH = 64;
    localparam int BYTES = W * DEPTH;
    localparam int AW    = $clog2(DEPTH) + $clog2(W);
    localparam int WAW   = $clog2(DEPTH);

    logic           clk;
    logic           reset;
    logic           req_valid_in;
    logic           req_ready_out;
    logic           req_write_in;
    logic [AW-1:0]  req_addr_in;
    logic [1:0]     req_size_in;
    logic           req_signed_in;
    logic [31:0]    req_data_in;
    logic           resp_valid_out;
    logic [31:0]    resp_data_out;
    logic [WAW-1:0] mem_write_addr_out;
    logic           mem_write_out;
    logic [31:0]    mem_write_data_out;
    logic [3:0]     mem_write_mask_out;
    logic [WAW-1:0] mem_read_addr_out;
    logic           mem_read_out;
    logic [31:0]    mem_read_data_in;
    logic           debugen_in;

    int n_checks;
    int n_errors;

    logic [31:0] ram [DEPTH];
    logic [31:0] init_words [DEPTH];
    logic [7:0]  gold [BYTES];
    logic        tb_init;

    mem_access_aligner #(.MEM_WIDTH_BYTES(W), .MEM_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_in       (req_valid_in),
        .req_ready_out      (req_ready_out),
        .req_write_in       (req_write_in),
        .req_addr_in        (req_addr_in),
        .req_size_in        (req_size_in),
        .req_signed_in      (req_signed_in),
        .req_data_in        (req_data_in),
        .resp_valid_out     (resp_valid_out),
        .resp_data_out      (resp_data_out),
        .mem_write_addr_out (mem_write_addr_out),
        .mem_write_out      (mem_write_out),
        .mem_write_data_out (mem_write_data_out),
        .mem_write_mask_out (mem_write_mask_out),
        .mem_read_addr_out  (mem_read_addr_out),
        .mem_read_out       (mem_read_out),
        .mem_read_data_in   (mem_read_data_in),
        .debugen_in         (debugen_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-masked memory with registered read.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int w = 0; w < DEPTH; w++) ram[w] <= init_words[w];
        end else if (mem_write_out) begin
            for (int b = 0; b < W; b++)
                if (mem_write_mask_out[b])
                    ram[mem_write_addr_out][8*b +: 8] <= mem_write_data_out[8*b +: 8];
        end
        if (mem_read_out) mem_read_data_in <= ram[mem_read_addr_out];
    end

    // Reference: little-endian bytes, addresses wrap modulo memory size.
    function automatic logic [31:0] ref_load(input int addr, input int sz, input logic sg);
        int          n = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = gold[(addr + i) % BYTES];
        if (sg && n < W && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input int addr, input int sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++) gold[(addr + i) % BYTES] = d[8*i +: 8];
    endtask

    task automatic drive(input logic wr, input int addr, input int sz, input logic sg,
                         input logic [31:0] d);
        req_valid_in  = 1'b1;
        req_write_in  = wr;
        req_addr_in   = AW'(addr);
        req_size_in   = 2'(sz);
        req_signed_in = sg;
        req_data_in   = d;
    endtask

    // Issues one load at the current cycle; returns data and cycles to response.
    task automatic do_load(input int addr, input int sz, input logic sg,
                           output logic [31:0] d, output int lat);
        lat = -1;
        d   = '0;
        drive(1'b0, addr, sz, sg, $urandom);
        for (int c = 1; c <= 4 && lat < 0; c++) begin
            @(negedge clk);
            req_valid_in = 1'b0;
            if (resp_valid_out) begin
                lat = c;
                d   = resp_data_out;
            end
        end
    endtask

    task automatic do_store(input int addr, input int sz, input logic [31:0] d);
        int guard = 0;
        drive(1'b1, addr, sz, 1'b0, d);
        @(negedge clk);
        req_valid_in = 1'b0;
        while (!req_ready_out && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        ref_store(addr, sz, d);
    endtask

    task automatic test_reset();
        drive(1'b0, 'h10, 2, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_ready_out !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b expected 0", req_ready_out); end
        n_checks++; if (resp_valid_out !== 1'b0) begin n_errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid_out); end
        n_checks++; if (mem_write_out !== 1'b0) begin n_errors++; $display("FAIL rst_mem_write: got %b expected 0", mem_write_out); end
        n_checks++; if (mem_read_out !== 1'b0) begin n_errors++; $display("FAIL rst_mem_read: got %b expected 0", mem_read_out); end
        @(negedge clk);
        req_valid_in = 1'b0;
        reset        = 1'b0;
        #1;
        n_checks++; if (req_ready_out !== 1'b1) begin n_errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready_out); end
        @(negedge clk);
    endtask

    task automatic test_plan();
        logic [31:0] d;
        int          lat;
        // Aligned word store
        drive(1'b1, 'h10, 2, 1'b0, 32'h11223344);
        #1;
        n_checks++; if (mem_write_out !== 1'b1 || mem_write_addr_out !== 6'd4) begin n_errors++; $display("FAIL st_w_addr: got wr=%b addr=%0d expected wr=1 addr=4", mem_write_out, mem_write_addr_out); end
        n_checks++; if (mem_write_mask_out !== 4'hF || mem_write_data_out !== 32'h11223344) begin n_errors++; $display("FAIL st_w_data: got mask=%h data=%h expected mask=f data=11223344", mem_write_mask_out, mem_write_data_out); end
        @(negedge clk);
        req_valid_in = 1'b0;
        ref_store('h10, 2, 32'h11223344);
        // Aligned word load
        drive(1'b0, 'h10, 2, 1'b0, 32'h0);
        #1;
        n_checks++; if (mem_read_out !== 1'b1 || mem_read_addr_out !== 6'd4) begin n_errors++; $display("FAIL ld_w_addr: got rd=%b addr=%0d expected rd=1 addr=4", mem_read_out, mem_read_addr_out); end
        @(negedge clk);
        req_valid_in = 1'b0;
        n_checks++; if (resp_valid_out !== 1'b1 || resp_data_out !== 32'h11223344) begin n_errors++; $display("FAIL ld_w_resp: got v=%b data=%h expected v=1 data=11223344", resp_valid_out, resp_data_out); end
        @(negedge clk);
        n_checks++; if (resp_valid_out !== 1'b0) begin n_errors++; $display("FAIL ld_w_resp_once: got %b expected 0", resp_valid_out); end
        // Byte store / loads
        drive(1'b1, 'h13, 0, 1'b0, 32'h000000AB);
        #1;
        n_checks++; if (mem_write_mask_out !== 4'b1000 || mem_write_data_out !== 32'hAB000000) begin n_errors++; $display("FAIL st_b: got mask=%b data=%h expected mask=1000 data=ab000000", mem_write_mask_out, mem_write_data_out); end
        @(negedge clk);
        req_valid_in = 1'b0;
        ref_store('h13, 0, 32'hAB);
        do_load('h13, 0, 1'b1, d, lat);
        n_checks++; if (lat !== 1 || d !== 32'hFFFFFFAB) begin n_errors++; $display("FAIL ld_b_signed: got lat=%0d data=%h expected lat=1 data=ffffffab", lat, d); end
        do_load('h13, 0, 1'b0, d, lat);
        n_checks++; if (lat !== 1 || d !== 32'h000000AB) begin n_errors++; $display("FAIL ld_b_unsigned: got lat=%0d data=%h expected lat=1 data=000000ab", lat, d); end
        // Misaligned half store
        drive(1'b1, 'h17, 1, 1'b0, 32'h0000BEEF);
        #1;
        n_checks++; if (mem_write_addr_out !== 6'd5 || mem_write_mask_out !== 4'b1000 || mem_write_data_out !== 32'hEF000000) begin n_errors++; $display("FAIL st_h_beat0: got addr=%0d mask=%b data=%h expected addr=5 mask=1000 data=ef000000", mem_write_addr_out, mem_write_mask_out, mem_write_data_out); end
        @(negedge clk);
        req_valid_in = 1'b0;
        #1;
        n_checks++; if (mem_write_out !== 1'b1 || mem_write_addr_out !== 6'd6 || mem_write_mask_out !== 4'b0001 || mem_write_data_out !== 32'h000000BE) begin n_errors++; $display("FAIL st_h_beat1: got wr=%b addr=%0d mask=%b data=%h expected wr=1 addr=6 mask=0001 data=000000be", mem_write_out, mem_write_addr_out, mem_write_mask_out, mem_write_data_out); end
        n_checks++; if (req_ready_out !== 1'b0) begin n_errors++; $display("FAIL st_h_ready: got %b expected 0", req_ready_out); end
        @(negedge clk);
        ref_store('h17, 1, 32'hBEEF);
        n_checks++; if (req_ready_out !== 1'b1 || mem_write_out !== 1'b0) begin n_errors++; $display("FAIL st_h_done: got ready=%b wr=%b expected ready=1 wr=0", req_ready_out, mem_write_out); end
        do_load('h17, 1, 1'b1, d, lat);
        n_checks++; if (lat !== 2 || d !== 32'hFFFFBEEF) begin n_errors++; $display("FAIL ld_h_split: got lat=%0d data=%h expected lat=2 data=ffffbeef", lat, d); end
        // Word load wrapping from the last word to word 0
        drive(1'b0, BYTES - 2, 2, 1'b0, 32'h0);
        #1;
        n_checks++; if (mem_read_addr_out !== 6'(DEPTH - 1)) begin n_errors++; $display("FAIL wrap_rd0: got %0d expected %0d", mem_read_addr_out, DEPTH - 1); end
        @(negedge clk);
        req_valid_in = 1'b0;
        #1;
        n_checks++; if (mem_read_out !== 1'b1 || mem_read_addr_out !== 6'd0 || resp_valid_out !== 1'b0) begin n_errors++; $display("FAIL wrap_rd1: got rd=%b addr=%0d v=%b expected rd=1 addr=0 v=0", mem_read_out, mem_read_addr_out, resp_valid_out); end
        @(negedge clk);
        d = ref_load(BYTES - 2, 2, 1'b0);
        n_checks++; if (resp_valid_out !== 1'b1 || resp_data_out !== d) begin n_errors++; $display("FAIL wrap_resp: got v=%b data=%h expected v=1 data=%h", resp_valid_out, resp_data_out, d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] st;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b0, 'h40 + 4*i, 2, 1'b0, 32'h0);
            else req_valid_in = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                d = ref_load('h40 + 4*i, 2, 1'b0);
                n_checks++; if (resp_valid_out !== 1'b1 || resp_data_out !== d) begin n_errors++; $display("FAIL b2b_load%0d: got v=%b data=%h expected v=1 data=%h", i, resp_valid_out, resp_data_out, d); end
            end else begin
                n_checks++; if (resp_valid_out !== 1'b0) begin n_errors++; $display("FAIL b2b_end: got %b expected 0", resp_valid_out); end
            end
        end
        // Store immediately followed by a load of the same word
        st = $urandom;
        drive(1'b1, 'h50, 2, 1'b0, st);
        ref_store('h50, 2, st);
        @(negedge clk);
        drive(1'b0, 'h50, 2, 1'b0, 32'h0);
        @(negedge clk);
        req_valid_in = 1'b0;
        n_checks++; if (resp_valid_out !== 1'b1 || resp_data_out !== st) begin n_errors++; $display("FAIL st_then_ld: got v=%b data=%h expected v=1 data=%h", resp_valid_out, resp_data_out, st); end
        @(negedge clk);
    endtask

    task automatic test_reset_split();
        logic [31:0] d;
        logic [31:0] e;
        int          lat;
        drive(1'b1, 'h22, 2, 1'b0, 32'hCAFEF00D);
        #1;
        n_checks++; if (mem_write_out !== 1'b1 || mem_write_mask_out !== 4'b1100) begin n_errors++; $display("FAIL split_beat0: got wr=%b mask=%b expected wr=1 mask=1100", mem_write_out, mem_write_mask_out); end
        @(negedge clk);
        req_valid_in = 1'b0;
        reset        = 1'b1;
        #1;
        n_checks++; if (mem_write_out !== 1'b0 || resp_valid_out !== 1'b0 || req_ready_out !== 1'b0) begin n_errors++; $display("FAIL split_reset: got wr=%b v=%b ready=%b expected 0 0 0", mem_write_out, resp_valid_out, req_ready_out); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready_out !== 1'b1 || mem_write_out !== 1'b0) begin n_errors++; $display("FAIL split_release: got ready=%b wr=%b expected ready=1 wr=0", req_ready_out, mem_write_out); end
        // Only the first beat reached memory.
        gold['h22] = 8'h0D;
        gold['h23] = 8'hF0;
        do_load('h20, 2, 1'b0, d, lat);
        e = ref_load('h20, 2, 1'b0);
        n_checks++; if (lat !== 1 || d !== e) begin n_errors++; $display("FAIL split_word0: got lat=%0d data=%h expected lat=1 data=%h", lat, d, e); end
        do_load('h24, 2, 1'b0, d, lat);
        e = ref_load('h24, 2, 1'b0);
        n_checks++; if (lat !== 1 || d !== e) begin n_errors++; $display("FAIL split_word1: got lat=%0d data=%h expected lat=1 data=%h", lat, d, e); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        int          lat;
        int          exp_lat;
        int          addr;
        int          sz;
        logic        sg;
        for (int i = 0; i < 300; i++) begin
            addr = $urandom_range(0, BYTES - 1);
            sz   = $urandom_range(0, 2);
            sg   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                do_store(addr, sz, $urandom);
            end else begin
                exp_lat = ((addr % W) + (1 << sz) > W) ? 2 : 1;
                do_load(addr, sz, sg, d, lat);
                e = ref_load(addr, sz, sg);
                n_checks++; if (lat !== exp_lat || d !== e) begin n_errors++; $display("FAIL rnd_load%0d addr=%h size=%0d signed=%b: got lat=%0d data=%h expected lat=%0d data=%h", i, addr, sz, sg, lat, d, exp_lat, e); end
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        debugen_in    = 1'b0;
        req_valid_in  = 1'b0;
        req_write_in  = 1'b0;
        req_addr_in   = '0;
        req_size_in   = '0;
        req_signed_in = 1'b0;
        req_data_in   = '0;
        for (int w = 0; w < DEPTH; w++) begin
            v             = $urandom;
            init_words[w] = v;
            for (int b = 0; b < W; b++) gold[W*w + b] = v[8*b +: 8];
        end
        tb_init = 1'b1;
        @(negedge clk);
        tb_init = 1'b0;
        test_reset();
        test_plan();
        test_back_to_back();
        test_reset_split();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_access_aligner
`default_nettype wire
